// File: rtl/param_seq_shifter.sv
// Multi-step WIDTH-bit shift register: parallel load, then Count single-bit steps per Start.
// Define SHIFTER_ROTATE_EN to build the rotate datapath; otherwise Mode 10 acts as logical.
module param_seq_shifter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Load_n,
  input  logic [WIDTH-1:0] Load_Val,
  input  logic             Start,
  input  logic [CNT_W-1:0] Count,
  input  logic             Dir,
  input  logic [1:0]       Mode,
  input  logic             Ser_In,
  output logic [WIDTH-1:0] Q,
  output logic             Busy,
  output logic             Done,
  output logic             Ser_Out,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic             dir_l;
  logic [1:0]       mode_l;
  logic             fill;
  logic             departing;
  logic [WIDTH-1:0] shifted;

  // Handshake: Start is accepted only in IDLE with Load_n high; Busy is high exactly in SHIFT,
  // Done is a one-cycle pulse exactly in DONE; no new Start is taken until back in IDLE.
  always_comb begin
    fill = 1'b0;
    case (mode_l)
      2'b01: fill = dir_l ? Q[WIDTH-1] : 1'b0;
`ifdef SHIFTER_ROTATE_EN
      2'b10: fill = dir_l ? Q[0] : Q[WIDTH-1];
`endif
      2'b11: fill = Ser_In;
      default: fill = 1'b0;
    endcase
    departing = dir_l ? Q[0] : Q[WIDTH-1];
    shifted   = dir_l ? {fill, Q[WIDTH-1:1]} : {Q[WIDTH-2:0], fill};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st      <= IDLE;
      Q       <= '0;
      cnt     <= '0;
      dir_l   <= 1'b0;
      mode_l  <= 2'b00;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      Ser_Out <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (!Load_n) begin
            Q <= Load_Val;
          end else if (Start) begin
            dir_l  <= Dir;
            mode_l <= Mode;
            if (Count == '0) begin
              st   <= DONE;
              Done <= 1'b1;
            end else begin
              cnt  <= Count;
              st   <= SHIFT;
              Busy <= 1'b1;
            end
          end
        end
        SHIFT: begin
          Q       <= shifted;
          Ser_Out <= departing;
          cnt     <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            st   <= DONE;
            Busy <= 1'b0;
            Done <= 1'b1;
          end
        end
        DONE: begin
          Done <= 1'b0;
          st   <= IDLE;
        end
        default: begin
          st   <= IDLE;
          Busy <= 1'b0;
          Done <= 1'b0;
        end
      endcase
    end
  end

  assign fsm_state = st;

endmodule
